trap_seq: RTL and testbench

- Trap/return sequencer placed between the WBU and the machine-mode CSR file.
- Accepts retiring instructions and forwards plain CSR-instruction writes unchanged.
- For ecall/illegal-instruction, runs a multi-cycle trap-entry sequence over the CSR file's single write port: writes mepc, mcause and mstatus, then redirects the PC to mtvec.
- For mret, restores mstatus and redirects the PC to mepc.

---
 rtl/trap_seq_if.sv | 44 ++++
 rtl/trap_seq.sv | 184 ++++++++++++++++++
 tb/tb_trap_seq.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/trap_seq_if.sv
// Trap sequencer bundle: retiring-instruction handshake, CSR snapshot, CSR write port, PC redirect.
// Latency: none (pure wiring); timing is owned by trap_seq.
// Backpressure: in_ready from the sequencer; the WBU holds its instruction until in_ready.
interface trap_seq_if #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 32
);
    // Retiring instruction from the WBU
    logic                  in_valid;
    logic                  in_ready;
    logic                  in_is_ecall;
    logic                  in_is_mret;
    logic                  in_is_illegal;
    logic [DATA_WIDTH-1:0] in_pc;
    logic [DATA_WIDTH-1:0] in_inst;
    logic                  in_csr_wen;
    logic [ADDR_WIDTH-1:0] in_csr_waddr;
    logic [DATA_WIDTH-1:0] in_csr_wdata;

    // Current machine-mode CSR values
    logic [DATA_WIDTH-1:0] mstatus_q;
    logic [DATA_WIDTH-1:0] mtvec_q;
    logic [DATA_WIDTH-1:0] mepc_q;

    // CSR file write port and PC redirect
    logic                  csr_wen;
    logic [ADDR_WIDTH-1:0] csr_waddr;
    logic [DATA_WIDTH-1:0] csr_wdata;
    logic                  redirect_valid;
    logic [DATA_WIDTH-1:0] redirect_pc;
    logic                  busy;

    modport master (
        output in_valid, in_is_ecall, in_is_mret, in_is_illegal, in_pc, in_inst,
               in_csr_wen, in_csr_waddr, in_csr_wdata, mstatus_q, mtvec_q, mepc_q,
        input  in_ready, csr_wen, csr_waddr, csr_wdata, redirect_valid, redirect_pc, busy
    );

    modport slave (
        input  in_valid, in_is_ecall, in_is_mret, in_is_illegal, in_pc, in_inst,
               in_csr_wen, in_csr_waddr, in_csr_wdata, mstatus_q, mtvec_q, mepc_q,
        output in_ready, csr_wen, csr_waddr, csr_wdata, redirect_valid, redirect_pc, busy
    );
endinterface

// File: rtl/trap_seq.sv
// Trap/return sequencer between WBU and M-mode CSR file; TRAP_SEQ_MTVAL_EN adds an mtval write.
// Latency: CSR pass-through same cycle; trap redirect at t+4 (t+5 with mtval); mret redirect at t+2.
// Backpressure: in_ready only in IDLE; in_* ignored while busy, next accept the cycle after redirect.
module trap_seq #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 32
) (
    input logic       clk,
    input logic       rst,
    trap_seq_if.slave bus
);

    localparam logic [ADDR_WIDTH-1:0] CSR_MSTATUS = ADDR_WIDTH'(12'h300);
    localparam logic [ADDR_WIDTH-1:0] CSR_MEPC    = ADDR_WIDTH'(12'h341);
    localparam logic [ADDR_WIDTH-1:0] CSR_MCAUSE  = ADDR_WIDTH'(12'h342);
    localparam logic [ADDR_WIDTH-1:0] CSR_MTVAL   = ADDR_WIDTH'(12'h343);

    localparam logic [3:0] CAUSE_ILLEGAL = 4'd2;
    localparam logic [3:0] CAUSE_ECALL   = 4'd11;

    typedef enum logic [2:0] {
        IDLE,
        T_MEPC,
        T_MCAUSE,
        T_MSTATUS,
        T_MTVAL,
        T_REDIR,
        R_MSTATUS,
        R_REDIR
    } state_t;

    state_t                state_q;
    state_t                state_d;

    logic [DATA_WIDTH-1:0] pc_q;
    logic [3:0]            cause_q;
`ifdef TRAP_SEQ_MTVAL_EN
    logic [DATA_WIDTH-1:0] inst_q;
`endif

    logic                  trap_req;
    logic                  accept_trap;
    logic [DATA_WIDTH-1:0] mst_trap;
    logic [DATA_WIDTH-1:0] mst_ret;

    logic                  in_ready;
    logic                  busy;
    logic                  csr_wen;
    logic [ADDR_WIDTH-1:0] csr_waddr;
    logic [DATA_WIDTH-1:0] csr_wdata;
    logic                  redirect_valid;
    logic [DATA_WIDTH-1:0] redirect_pc;

    // illegal outranks ecall, both outrank mret; capture happens only on an IDLE accept
    assign trap_req    = bus.in_is_illegal || bus.in_is_ecall;
    assign accept_trap = (state_q == IDLE) && bus.in_valid && trap_req;

    // mstatus images for trap entry (MPIE<=MIE, MIE<=0, MPP<=M) and mret (MIE<=MPIE, MPIE<=1, MPP<=M)
    always_comb begin
        mst_trap        = bus.mstatus_q;
        mst_trap[7]     = bus.mstatus_q[3];
        mst_trap[3]     = 1'b0;
        mst_trap[12:11] = 2'b11;
        mst_ret         = bus.mstatus_q;
        mst_ret[3]      = bus.mstatus_q[7];
        mst_ret[7]      = 1'b1;
        mst_ret[12:11]  = 2'b11;
    end

    // State register; reset aborts any sequence in flight
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Trap context captured at accept so later sequence cycles do not depend on the WBU
    always_ff @(posedge clk) begin
        if (!rst) begin
            pc_q    <= '0;
            cause_q <= '0;
`ifdef TRAP_SEQ_MTVAL_EN
            inst_q  <= '0;
`endif
        end else if (accept_trap) begin
            pc_q    <= bus.in_pc;
            cause_q <= bus.in_is_illegal ? CAUSE_ILLEGAL : CAUSE_ECALL;
`ifdef TRAP_SEQ_MTVAL_EN
            inst_q  <= bus.in_inst;
`endif
        end
    end

    // Next state and outputs, decoded from state plus captured context
    always_comb begin
        state_d        = state_q;
        in_ready       = 1'b0;
        busy           = 1'b1;
        csr_wen        = 1'b0;
        csr_waddr      = '0;
        csr_wdata      = '0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (bus.in_valid) begin
                    if (trap_req) begin
                        state_d = T_MEPC;
                    end else if (bus.in_is_mret) begin
                        state_d = R_MSTATUS;
                    end else begin
                        csr_wen   = bus.in_csr_wen;
                        csr_waddr = bus.in_csr_waddr;
                        csr_wdata = bus.in_csr_wdata;
                    end
                end
            end
            T_MEPC: begin
                csr_wen   = 1'b1;
                csr_waddr = CSR_MEPC;
                csr_wdata = pc_q;
                state_d   = T_MCAUSE;
            end
            T_MCAUSE: begin
                csr_wen   = 1'b1;
                csr_waddr = CSR_MCAUSE;
                csr_wdata = {{(DATA_WIDTH-4){1'b0}}, cause_q};
                state_d   = T_MSTATUS;
            end
            T_MSTATUS: begin
                csr_wen   = 1'b1;
                csr_waddr = CSR_MSTATUS;
                csr_wdata = mst_trap;
`ifdef TRAP_SEQ_MTVAL_EN
                state_d   = T_MTVAL;
`else
                state_d   = T_REDIR;
`endif
            end
            T_MTVAL: begin
`ifdef TRAP_SEQ_MTVAL_EN
                csr_wen   = 1'b1;
                csr_waddr = CSR_MTVAL;
                csr_wdata = (cause_q == CAUSE_ILLEGAL) ? inst_q : '0;
                state_d   = T_REDIR;
`else
                state_d   = IDLE;
`endif
            end
            T_REDIR: begin
                redirect_valid = 1'b1;
                redirect_pc    = {bus.mtvec_q[DATA_WIDTH-1:2], 2'b00};
                state_d        = IDLE;
            end
            R_MSTATUS: begin
                csr_wen   = 1'b1;
                csr_waddr = CSR_MSTATUS;
                csr_wdata = mst_ret;
                state_d   = R_REDIR;
            end
            R_REDIR: begin
                redirect_valid = 1'b1;
                redirect_pc    = bus.mepc_q;
                state_d        = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.in_ready       = in_ready;
    assign bus.busy           = busy;
    assign bus.csr_wen        = csr_wen;
    assign bus.csr_waddr      = csr_waddr;
    assign bus.csr_wdata      = csr_wdata;
    assign bus.redirect_valid = redirect_valid;
    assign bus.redirect_pc    = redirect_pc;

endmodule

// File: tb/tb_trap_seq.sv
// Self-checking bench for trap_seq: directed vector table, hand sequences, randomized model check.
// Each transaction is expanded into the per-cycle observation list the sequencer must produce.
// Define TRAP_SEQ_MTVAL_EN for both RTL and bench to check the mtval build.
module tb_trap_seq;

    localparam int AW = 12;
    localparam int DW = 32;

    typedef struct packed {
        logic          ecall;
        logic          mret;
        logic          illegal;
        logic [DW-1:0] pc;
        logic [DW-1:0] inst;
        logic          cwen;
        logic [AW-1:0] caddr;
        logic [DW-1:0] cdata;
        logic [DW-1:0] mst;
        logic [DW-1:0] mtvec;
        logic [DW-1:0] mepc;
    } txn_t;

    typedef struct packed {
        logic          wen;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic          rv;
        logic [DW-1:0] rpc;
        logic          busy;
        logic          rdy;
    } obs_t;

    typedef struct {
        string         name;
        txn_t          t;
        logic [DW-1:0] exp_cause;
        logic [DW-1:0] exp_mstw;
        logic [DW-1:0] exp_rpc;
        logic [DW-1:0] exp_mtval;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    trap_seq_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    trap_seq #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int   n_pass  = 0;
    int   n_total = 0;
    obs_t exp_q[$];
    txn_t zero_t;

    function automatic obs_t sample();
        obs_t o;
        o.wen  = bus.csr_wen;
        o.addr = bus.csr_wen ? bus.csr_waddr : '0;
        o.data = bus.csr_wen ? bus.csr_wdata : '0;
        o.rv   = bus.redirect_valid;
        o.rpc  = bus.redirect_valid ? bus.redirect_pc : '0;
        o.busy = bus.busy;
        o.rdy  = bus.in_ready;
        return o;
    endfunction

    function automatic obs_t mk(logic wen, logic [AW-1:0] a, logic [DW-1:0] d,
                                logic rv, logic [DW-1:0] rpc, logic busy, logic rdy);
        obs_t o;
        o.wen  = wen;
        o.addr = wen ? a : '0;
        o.data = wen ? d : '0;
        o.rv   = rv;
        o.rpc  = rv ? rpc : '0;
        o.busy = busy;
        o.rdy  = rdy;
        return o;
    endfunction

    task automatic check(input string name, input obs_t got, input obs_t exp);
        n_total++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got wen=%0b addr=%h data=%h rv=%0b rpc=%h busy=%0b rdy=%0b, expected wen=%0b addr=%h data=%h rv=%0b rpc=%h busy=%0b rdy=%0b",
                     name, got.wen, got.addr, got.data, got.rv, got.rpc, got.busy, got.rdy,
                     exp.wen, exp.addr, exp.data, exp.rv, exp.rpc, exp.busy, exp.rdy);
        end
    endtask

    task automatic set_in(input txn_t t, input logic v);
        bus.in_valid      = v;
        bus.in_is_ecall   = t.ecall;
        bus.in_is_mret    = t.mret;
        bus.in_is_illegal = t.illegal;
        bus.in_pc         = t.pc;
        bus.in_inst       = t.inst;
        bus.in_csr_wen    = t.cwen;
        bus.in_csr_waddr  = t.caddr;
        bus.in_csr_wdata  = t.cdata;
    endtask

    task automatic set_csr(input txn_t t);
        bus.mstatus_q = t.mst;
        bus.mtvec_q   = t.mtvec;
        bus.mepc_q    = t.mepc;
    endtask

    function automatic txn_t rand_txn();
        txn_t t;
        t.ecall   = ($urandom_range(0, 3) == 0);
        t.mret    = ($urandom_range(0, 3) == 0);
        t.illegal = ($urandom_range(0, 4) == 0);
        t.pc      = $urandom;
        t.inst    = $urandom;
        t.cwen    = $urandom_range(0, 1);
        t.caddr   = AW'($urandom);
        t.cdata   = $urandom;
        t.mst     = $urandom;
        t.mtvec   = $urandom;
        t.mepc    = $urandom;
        return t;
    endfunction

    // Expected cycle list: accept cycle, sequence cycles, then one IDLE cycle
    // (which shows the held instruction's pass-through when hold is set).
    task automatic build_steps(input txn_t t, input logic [DW-1:0] cause, input logic [DW-1:0] mstw,
                               input logic [DW-1:0] rpc, input logic [DW-1:0] mtval,
                               input bit hold, input txn_t held);
        exp_q.delete();
        if (t.illegal || t.ecall) begin
            exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 1));
            exp_q.push_back(mk(1, 12'h341, t.pc, 0, 0, 1, 0));
            exp_q.push_back(mk(1, 12'h342, cause, 0, 0, 1, 0));
            exp_q.push_back(mk(1, 12'h300, mstw, 0, 0, 1, 0));
`ifdef TRAP_SEQ_MTVAL_EN
            exp_q.push_back(mk(1, 12'h343, mtval, 0, 0, 1, 0));
`endif
            exp_q.push_back(mk(0, 0, 0, 1, rpc, 1, 0));
        end else if (t.mret) begin
            exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 1));
            exp_q.push_back(mk(1, 12'h300, mstw, 0, 0, 1, 0));
            exp_q.push_back(mk(0, 0, 0, 1, rpc, 1, 0));
        end else begin
            exp_q.push_back(mk(t.cwen, t.caddr, t.cdata, 0, 0, 0, 1));
        end
        if (hold) exp_q.push_back(mk(held.cwen, held.caddr, held.cdata, 0, 0, 0, 1));
        else      exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 1));
`ifndef TRAP_SEQ_MTVAL_EN
        if (mtval != mtval) exp_q.delete();
`endif
    endtask

    // Behavioural reference: CSR results straight from the privileged-architecture rules
    task automatic model_steps(input txn_t t);
        logic [DW-1:0] cause, mstw, rpc, mtval;
        cause = t.illegal ? 32'd2 : 32'd11;
        mtval = t.illegal ? t.inst : 32'd0;
        if (t.illegal || t.ecall) begin
            mstw = (t.mst & ~32'h88) | (((t.mst >> 3) & 32'd1) << 7) | 32'h1800;
            rpc  = t.mtvec - (t.mtvec % 4);
        end else begin
            mstw = (t.mst & ~32'h8) | (((t.mst >> 7) & 32'd1) << 3) | 32'h80 | 32'h1800;
            rpc  = t.mepc;
        end
        build_steps(t, cause, mstw, rpc, mtval, 0, zero_t);
    endtask

    // Drive one transaction and compare every cycle against exp_q.
    // While busy, either a held instruction or random ignored traffic is presented.
    task automatic run_seq(input string name, input txn_t t, input bit hold, input txn_t held);
        int last;
        last = exp_q.size() - 1;
        @(negedge clk);
        set_csr(t);
        set_in(t, 1'b1);
        #1;
        check({name, "/accept"}, sample(), exp_q[0]);
        for (int k = 1; k <= last; k++) begin
            @(posedge clk);
            #1;
            if (hold)           set_in(held, 1'b1);
            else if (k == last) set_in(zero_t, 1'b0);
            else                set_in(rand_txn(), 1'($urandom_range(0, 1)));
            #1;
            check($sformatf("%s/cyc%0d", name, k), sample(), exp_q[k]);
        end
        @(posedge clk);
        #1;
        set_in(zero_t, 1'b0);
    endtask

    vec_t vecs[$];
    vec_t v;
    txn_t t;
    txn_t held;

    initial begin
        zero_t = '0;
        set_in(zero_t, 1'b0);
        set_csr(zero_t);

        // Directed vectors with hand-derived expectations
        t = '0; t.ecall = 1; t.pc = 32'h80000010; t.mst = 32'h1808; t.mtvec = 32'h80000101;
        vecs.push_back('{"ecall", t, 32'hB, 32'h1880, 32'h80000100, 32'h0});
        t = '0; t.mret = 1; t.mst = 32'h1880; t.mepc = 32'h80000014;
        vecs.push_back('{"mret", t, 32'h0, 32'h1888, 32'h80000014, 32'h0});
        t = '0; t.cwen = 1; t.caddr = 12'h305; t.cdata = 32'h80000000;
        vecs.push_back('{"passthru", t, 32'h0, 32'h0, 32'h0, 32'h0});
        t = '0; t.illegal = 1; t.ecall = 1; t.pc = 32'h00001000; t.inst = 32'h12345678; t.mtvec = 32'h200;
        vecs.push_back('{"ill_ecall_prio", t, 32'h2, 32'h1800, 32'h200, 32'h12345678});
        t = '0; t.illegal = 1; t.pc = 32'h80000020; t.inst = 32'hFFFFFFFF; t.mst = 32'h8; t.mtvec = 32'h80000003;
        vecs.push_back('{"illegal_ones", t, 32'h2, 32'h1880, 32'h80000000, 32'hFFFFFFFF});
        t = '0; t.mret = 1; t.mst = 32'h0; t.mepc = 32'h400;
        vecs.push_back('{"mret_mpie0", t, 32'h0, 32'h1880, 32'h400, 32'h0});
        t = '0; t.mret = 1; t.ecall = 1; t.cwen = 1; t.caddr = 12'h305; t.mst = 32'h1800; t.mtvec = 32'h40; t.pc = 32'h44;
        vecs.push_back('{"ecall_over_mret", t, 32'hB, 32'h1800, 32'h40, 32'h0});

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("reset_state", sample(), mk(0, 0, 0, 0, 0, 0, 1));
        rst = 1'b1;

        // Directed table
        foreach (vecs[i]) begin
            v = vecs[i];
            build_steps(v.t, v.exp_cause, v.exp_mstw, v.exp_rpc, v.exp_mtval, 0, zero_t);
            run_seq(v.name, v.t, 0, zero_t);
        end

        // Reset mid-ecall: two reset edges abort the sequence, accept right after release
        @(negedge clk);
        t = vecs[0].t;
        set_csr(t);
        set_in(t, 1'b1);
        @(posedge clk);
        #1;
        set_in(zero_t, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(posedge clk);
            #1;
            check($sformatf("mid_reset/%0d", k), sample(), mk(0, 0, 0, 0, 0, 0, 1));
        end
        rst = 1'b1;
        build_steps(vecs[1].t, 0, vecs[1].exp_mstw, vecs[1].exp_rpc, 0, 0, zero_t);
        run_seq("after_reset_mret", vecs[1].t, 0, zero_t);

        // Backpressure: a CSR write held during an ecall is taken only once IDLE again
        held = '0; held.cwen = 1; held.caddr = 12'h305; held.cdata = 32'hA5A5A5A5;
        build_steps(vecs[0].t, vecs[0].exp_cause, vecs[0].exp_mstw, vecs[0].exp_rpc, 0, 1, held);
        run_seq("held_during_busy", vecs[0].t, 1, held);

        // Randomized transactions against the reference model
        for (int n = 0; n < 60; n++) begin
            t = rand_txn();
            model_steps(t);
            run_seq($sformatf("rand%0d", n), t, 0, zero_t);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
